// File: rtl/inst_mem_pipe_pkg.sv
// Shared bus widths, the NOP encoding returned for bad fetches, and small helpers
// used by the pipelined instruction memory.
package inst_mem_pipe_pkg;

   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   localparam logic [InstBus-1:0] NopInst = 32'h0000_0013;

   localparam int InstMemLatMax = 4;

   // Outstanding-request counter must reach InstMemLatMax + 1.
   localparam int OutsW = $clog2(InstMemLatMax + 2);

   // Modulo increment for FIFO pointers whose depth need not be a power of two.
   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/inst_mem_pipe_resp_fifo.sv
// Response FIFO holding {inst, addr, err}. The head is visible combinationally.
// Flush and reset both empty it in one edge.
module resp_fifo
   import inst_mem_pipe_pkg::*;
#(
   parameter int DEPTH  = 3,
   parameter int ADDR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic [InstBus-1:0] push_inst,
   input  logic [ADDR_W-1:0]  push_addr,
   input  logic               push_err,
   input  logic               pop,
   output logic               empty,
   output logic [InstBus-1:0] head_inst,
   output logic [ADDR_W-1:0]  head_addr,
   output logic               head_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [InstBus-1:0] inst_q [DEPTH];
   logic [ADDR_W-1:0]  addr_q [DEPTH];
   logic               err_q  [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   // Entry storage is not reset: only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_q[wr_ptr] <= push_inst;
         addr_q[wr_ptr] <= push_addr;
         err_q[wr_ptr]  <= push_err;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop keep the count.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= PW'(ptr_inc(int'(wr_ptr), DEPTH));
         if (pop)  rd_ptr <= PW'(ptr_inc(int'(rd_ptr), DEPTH));
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign empty     = (count == '0);
   assign head_inst = inst_q[rd_ptr];
   assign head_addr = addr_q[rd_ptr];
   assign head_err  = err_q[rd_ptr];

endmodule

// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory with a valid/ready fetch port, credit-based
// backpressure, flush for branch redirect and a word-write preload port.
// The final pipeline stage bypasses the FIFO when the FIFO is empty. This gives
// LATENCY cycles from accept to response. When the response is stalled, the
// entry moves into the FIFO, so the rsp_* values are unchanged next cycle.
module inst_mem_pipe
   import inst_mem_pipe_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 2,
   parameter int ADDR_W     = InstAddrBus
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic                  flush,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [InstBus-1:0]    rsp_inst,
   output logic [ADDR_W-1:0]     rsp_addr,
   output logic                  rsp_err,
   input  logic                  ld_we,
   input  logic [DEPTH_LOG2-1:0] ld_addr,
   input  logic [InstBus-1:0]    ld_data
);

   localparam int                 Words     = 1 << DEPTH_LOG2;
   localparam logic [OutsW-1:0]   OutsLimit = OutsW'(LATENCY);

   logic [InstBus-1:0] mem [Words];

   logic                  req_hs;
   logic                  rsp_hs;
   logic                  req_bad;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [OutsW-1:0]      outs;

   logic [LATENCY-1:0] pv;
   logic [InstBus-1:0] pinst [LATENCY];
   logic [ADDR_W-1:0]  paddr [LATENCY];
   logic               perr  [LATENCY];

   logic               last_valid;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_empty;
   logic [InstBus-1:0] fifo_inst;
   logic [ADDR_W-1:0]  fifo_addr;
   logic               fifo_err;

   assign req_idx = req_addr[DEPTH_LOG2+1:2];
   assign req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (DEPTH_LOG2 + 2)) != '0);

   // During a flush the in-flight count is about to be discarded, so it does not gate.
   assign req_ready = !rst && !ld_we && (flush || (outs <= OutsLimit));
   assign req_hs    = req_valid && req_ready;

   // Preload writes; storage keeps its contents across reset.
   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
   end

   // Stage 0 is the synchronous read. Bad addresses get the NOP and do not read memory.
   // Later stages delay the result. A flush clears them, but not a request accepted in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pinst[i] <= '0;
            paddr[i] <= '0;
            perr[i]  <= 1'b0;
         end
      end else begin
         pv[0] <= req_hs;
         if (req_hs) begin
            paddr[0] <= req_addr;
            perr[0]  <= req_bad;
            pinst[0] <= req_bad ? NopInst : mem[req_idx];
         end
         for (int i = 1; i < LATENCY; i++) begin
            pv[i]    <= flush ? 1'b0 : pv[i-1];
            pinst[i] <= pinst[i-1];
            paddr[i] <= paddr[i-1];
            perr[i]  <= perr[i-1];
         end
      end
   end

   assign last_valid = pv[LATENCY-1];
   assign fifo_push  = last_valid && !flush && !(fifo_empty && rsp_ready);
   assign fifo_pop   = !fifo_empty && rsp_ready && !flush;

   resp_fifo #(
      .DEPTH  (LATENCY + 1),
      .ADDR_W (ADDR_W)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (fifo_push),
      .push_inst (pinst[LATENCY-1]),
      .push_addr (paddr[LATENCY-1]),
      .push_err  (perr[LATENCY-1]),
      .pop       (fifo_pop),
      .empty     (fifo_empty),
      .head_inst (fifo_inst),
      .head_addr (fifo_addr),
      .head_err  (fifo_err)
   );

   assign rsp_valid = (!fifo_empty || last_valid) && !flush;
   assign rsp_hs    = rsp_valid && rsp_ready;

   // Response mux: FIFO head first; otherwise the final stage. Outputs are zero while idle.
   always_comb begin
      rsp_inst = '0;
      rsp_addr = '0;
      rsp_err  = 1'b0;
      if (rsp_valid) begin
         if (fifo_empty) begin
            rsp_inst = pinst[LATENCY-1];
            rsp_addr = paddr[LATENCY-1];
            rsp_err  = perr[LATENCY-1];
         end else begin
            rsp_inst = fifo_inst;
            rsp_addr = fifo_addr;
            rsp_err  = fifo_err;
         end
      end
   end

   // Credit counter: accepted requests not yet handed back to the consumer.
   always_ff @(posedge clk) begin
      if (rst) begin
         outs <= '0;
      end else if (flush) begin
         outs <= OutsW'(req_hs);
      end else begin
         outs <= outs + OutsW'(req_hs) - OutsW'(rsp_hs);
      end
   end

endmodule

// File: tb/tb_inst_mem_pipe.sv
module tb_inst_mem_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic [31:0] rsp_addr;
   logic        rsp_err;
   logic        ld_we;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_mem_pipe #(
      .DEPTH_LOG2 (10),
      .LATENCY    (2),
      .ADDR_W     (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_inst  (rsp_inst),
      .rsp_addr  (rsp_addr),
      .rsp_err   (rsp_err),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [9:0] a, input logic [31:0] d);
      ld_we   = 1'b1;
      ld_addr = a;
      ld_data = d;
      tick();
      ld_we   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
      rsp_ready = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
      tick(); tick();
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (rsp_inst !== 32'h0) begin errors++; $display("FAIL reset_rsp_inst got=%h exp=0", rsp_inst); end
      checks++; if (rsp_addr !== 32'h0) begin errors++; $display("FAIL reset_rsp_addr got=%h exp=0", rsp_addr); end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_inst [4];
      exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;
      for (int w = 0; w < 4; w++) load_word(10'(w), exp_inst[w]);
      rsp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         req_valid = (k < 4);
         req_addr  = 32'(k * 4);
         #1;
         if (k < 4) begin
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready cyc=%0d got=%b exp=1", k, req_ready); end
         end
         if (k >= 2 && k <= 5) begin
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=1", k, rsp_valid); end
            checks++; if (rsp_inst !== exp_inst[k-2]) begin errors++; $display("FAIL b2b_rsp_inst cyc=%0d got=%h exp=%h", k, rsp_inst, exp_inst[k-2]); end
            checks++; if (rsp_addr !== 32'((k - 2) * 4)) begin errors++; $display("FAIL b2b_rsp_addr cyc=%0d got=%h exp=%h", k, rsp_addr, (k - 2) * 4); end
         end else begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle cyc=%0d got=%b exp=0", k, rsp_valid); end
         end
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int acc = 0;
      logic [31:0] exp_inst [3];
      exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         req_addr = 32'(acc * 4);
         #1;
         checks++; if (req_ready !== (k < 3)) begin errors++; $display("FAIL bp_req_ready cyc=%0d got=%b exp=%b", k, req_ready, (k < 3)); end
         if (k >= 2) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h0 || rsp_inst !== 32'h11) begin
               errors++; $display("FAIL bp_hold cyc=%0d got v=%b a=%h i=%h exp v=1 a=0 i=11", k, rsp_valid, rsp_addr, rsp_inst);
            end
         end
         if (req_ready) acc++;
         tick();
      end
      checks++; if (acc !== 3) begin errors++; $display("FAIL bp_accepts got=%0d exp=3", acc); end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int d = 0; d < 4; d++) begin
         #1;
         checks++; if (req_ready !== (d != 0)) begin errors++; $display("FAIL drain_req_ready cyc=%0d got=%b exp=%b", d, req_ready, (d != 0)); end
         if (d < 3) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'(d * 4) || rsp_inst !== exp_inst[d]) begin
               errors++; $display("FAIL drain_rsp cyc=%0d got v=%b a=%h i=%h exp v=1 a=%h i=%h", d, rsp_valid, rsp_addr, rsp_inst, d * 4, exp_inst[d]);
            end
         end else begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", rsp_valid); end
         end
         tick();
      end
   endtask

   task automatic test_flush();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h0; tick();
      req_addr = 32'h4; tick();
      req_addr = 32'h8; flush = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready got=%b exp=1", req_ready); end
      tick();
      flush = 1'b0; req_valid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_killed got=%b exp=0", rsp_valid); end
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h8 || rsp_inst !== 32'h33) begin
         errors++; $display("FAIL flush_target got v=%b a=%h i=%h exp v=1 a=8 i=33", rsp_valid, rsp_addr, rsp_inst);
      end
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_after got=%b exp=0", rsp_valid); end
      tick();
   endtask

   task automatic test_err();
      logic [31:0] addrs [3];
      logic [31:0] exp_inst [3];
      logic        exp_err [3];
      addrs[0] = 32'h6;    exp_inst[0] = 32'h13;       exp_err[0] = 1'b1;
      addrs[1] = 32'h1000; exp_inst[1] = 32'h13;       exp_err[1] = 1'b1;
      addrs[2] = 32'hFFC;  exp_inst[2] = 32'hDEADBEEF; exp_err[2] = 1'b0;
      load_word(10'd1023, 32'hDEADBEEF);
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         req_valid = (k < 3);
         req_addr  = (k < 3) ? addrs[k] : 32'h0;
         #1;
         if (k >= 2) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_addr !== addrs[k-2] || rsp_inst !== exp_inst[k-2] || rsp_err !== exp_err[k-2]) begin
               errors++; $display("FAIL err_rsp cyc=%0d got v=%b a=%h i=%h e=%b exp v=1 a=%h i=%h e=%b",
                                  k, rsp_valid, rsp_addr, rsp_inst, rsp_err, addrs[k-2], exp_inst[k-2], exp_err[k-2]);
            end
         end
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_load_priority();
      rsp_ready = 1'b1;
      ld_we = 1'b1; ld_addr = 10'd1; ld_data = 32'hAB;
      req_valid = 1'b1; req_addr = 32'h4;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL ld_req_ready got=%b exp=0", req_ready); end
      tick();
      ld_we = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ld_after_ready got=%b exp=1", req_ready); end
      tick();
      req_valid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ld_no_early_rsp got=%b exp=0", rsp_valid); end
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'hAB || rsp_addr !== 32'h4 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL ld_new_data got v=%b i=%h a=%h e=%b exp v=1 i=ab a=4 e=0", rsp_valid, rsp_inst, rsp_addr, rsp_err);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h8; tick();
      req_addr = 32'hC; tick();
      req_addr = 32'h0; tick();
      req_valid = 1'b0; tick();
      #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         errors++; $display("FAIL full_before_rst got v=%b rdy=%b exp v=1 rdy=0", rsp_valid, req_ready);
      end
      rst = 1'b1;
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_req_ready got=%b exp=0", req_ready); end
      tick();
      rst = 1'b0; rsp_ready = 1'b1;
      req_valid = 1'b1; req_addr = 32'h8;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", req_ready); end
      tick();
      req_addr = 32'h4; tick();
      req_valid = 1'b0;
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h8 || rsp_inst !== 32'h33) begin
         errors++; $display("FAIL rst_keep_mem0 got v=%b a=%h i=%h exp v=1 a=8 i=33", rsp_valid, rsp_addr, rsp_inst);
      end
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 32'h4 || rsp_inst !== 32'hAB) begin
         errors++; $display("FAIL rst_keep_mem1 got v=%b a=%h i=%h exp v=1 a=4 i=ab", rsp_valid, rsp_addr, rsp_inst);
      end
      tick();
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_final_idle got=%b exp=0", rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_err();
      test_load_priority();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inst_mem_pipe.md
# inst_mem_pipe

Parametrised pipelined instruction memory that replaces the single-cycle combinational instruction ROM in the minimal SoPC. It sits between the core's fetch stage and on-chip instruction storage. It has the following features:
- configurable depth and read latency;
- a valid/ready fetch handshake with backpressure;
- a flush for branch redirection;
- a word-write load port for program preloading;
- error flagging for bad fetch addresses.

## Interface
- `DEPTH_LOG2`, default 10: storage is 2^DEPTH_LOG2 32-bit words.
- `LATENCY`, default 2: cycles from request handshake to earliest response. Legal range 1..4.
- `ADDR_W`, default 32: byte-address width.
- `clk` — input, 1 — single clock, rising edge.
- `rst` — input, 1 — reset, synchronous, active-high.
- `req_valid` — input, 1 — fetch request valid.
- `req_ready` — output, 1 — request accepted this cycle if `req_valid` is also high.
- `req_addr` — input, `ADDR_W` — byte address of the instruction.
- `flush` — input, 1 — discard all in-flight and buffered responses.
- `rsp_valid` — output, 1 — response valid.
- `rsp_ready` — input, 1 — consumer accepts the response.
- `rsp_inst` — output, 32 — instruction word.
- `rsp_addr` — output, `ADDR_W` — byte address of the request that produced this response.
- `rsp_err` — output, 1 — address was misaligned or out of range.
- `ld_we` — input, 1 — load-port write enable.
- `ld_addr` — input, `DEPTH_LOG2` — word index to write.
- `ld_data` — input, 32 — word to write.

## Operation
- Request handshake: a request is taken when `req_valid && req_ready`.
- Responses return strictly in request order, one per request, unless removed by a flush.
- Word index is `req_addr[DEPTH_LOG2+1:2]`.
- Error case: `req_addr[1:0] != 0`, or any bit of `req_addr` above bit `DEPTH_LOG2+1` is set.
  - Response has `rsp_err`=1 and `rsp_inst`=0x00000013 (NOP).
  - Memory is not read.
- Outstanding counter `outs` counts accepted requests not yet consumed by a response handshake, range 0..`LATENCY`+1.
  - Incremented on request handshake.
  - Decremented on response handshake.
  - Both in the same cycle: unchanged.
- `req_ready` = `!rst && !ld_we && (outs <= LATENCY)`.
- Response FIFO holds `LATENCY`+1 entries. It never overflows because of the credit limit.
- Load port: while `ld_we`=1 the write has priority and `req_ready` is forced 0. Any request accepted afterwards observes the written data.
- In-flight reads already issued return the old data.
- Flush behaviour:
  - In the cycle `flush`=1, `rsp_valid` is forced 0, so no response handshake occurs.
  - All pipeline valids and FIFO entries are cleared at the edge.
  - `outs` becomes 1 if a request handshake occurs in the same cycle, else 0.
  - A request accepted in the flush cycle survives; it is the redirect target.
  - `req_ready` in the flush cycle uses `outs` as if it were 0.
- Reset mid-operation: the next edge clears the pipeline, FIFO and `outs`. Memory contents are preserved; storage is never reset.

## Timing
- Reset values:
  - `req_ready`=0 while `rst`=1.
  - `rsp_valid`=0, `rsp_inst`=0, `rsp_addr`=0, `rsp_err`=0.
  - `outs`=0.
- Latency: a request accepted in cycle t gives `rsp_valid`=1 in cycle t+`LATENCY` when the FIFO ahead of it is empty.
- Throughput: one response per cycle sustained with `rsp_ready` held high and `req_valid` held high.
- `rsp_*` are held stable while `rsp_valid && !rsp_ready` and no flush is active.
- No combinational path from `rsp_ready` to `req_ready`.

## Structure
- Shared defines header (existing bus macros) holds:
  - `InstAddrBus`, `InstBus`;
  - new `NopInst` (32'h00000013);
  - `InstMemLatMax` (4).
- Sub-module `resp_fifo`: synchronous FIFO of {inst, addr, err} with flush clear, parametrised by depth.
- Top `inst_mem_pipe` contains:
  - the storage array;
  - the `LATENCY`-stage valid/addr/err shift pipeline;
  - the credit counter.

## Test plan
- `LATENCY`=2: load words 0..3 = 0x11,0x22,0x33,0x44, then fetch 0x0,0x4,0x8,0xC back-to-back with `rsp_ready`=1.
  - Required: responses in cycles t+2..t+5, data 0x11..0x44, `rsp_addr` matching.
- Backpressure: hold `rsp_ready`=0 and keep issuing requests.
  - Required: `req_ready` drops after 3 accepts.
  - Required: releasing `rsp_ready` drains the 3 responses in order, then `req_ready` returns to 1.
- Flush with 2 requests in flight and a new request at 0x8 in the flush cycle.
  - Required: `rsp_valid`=0 in the flush cycle.
  - Required: only the 0x8 response appears, 2 cycles later.
- Fetch 0x6 and 0x1000 with `DEPTH_LOG2`=10.
  - Required: both responses have `rsp_err`=1 and `rsp_inst`=0x00000013.
- Assert `ld_we` to word 1 = 0xAB while `req_valid`=1 at 0x4.
  - Required: `req_ready`=0 during the write.
  - Required: the subsequent fetch returns 0xAB.
- Assert `rst` with the FIFO full.
  - Required: next cycle `rsp_valid`=0 and `req_ready`=0.
  - Required: after deassert, a fetch returns the data loaded before reset.
